// File: rtl/clock_div_detector.sv
// Measures the clk-cycle period between tick_in rises and decodes it to a power-of-two divide exponent, with lock/err/timeout status.
// Latency: a rise sampled at edge t updates period_out/valid at edge t (+2 cycles with CLK_DIV_DETECT_SYNC_EN for the synchroniser).
// Backpressure: none; the block free-runs on every clk and valid is a single-cycle pulse with no ready handshake.
module clock_div_detector #(
  parameter int CLK_DIV_SIZE = 3,
  parameter int CNT_WIDTH    = 2**CLK_DIV_SIZE + 1,
  parameter int LOCK_COUNT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    tick_in,
  output logic [CNT_WIDTH-1:0]    period_out,
  output logic [CLK_DIV_SIZE-1:0] div_out,
  output logic                    valid,
  output logic                    locked,
  output logic                    err,
  output logic                    timeout
);

  localparam int DIV_MAX = 2**CLK_DIV_SIZE - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_LOCKED} state_t;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [3:0]              match_cnt;
  logic                    tick_s;
  logic                    tick_q;
  logic                    rise;
  logic                    pow2;
  logic [CLK_DIV_SIZE-1:0] dec_k;
  logic                    same;
  logic [3:0]              match_inc;
  logic [3:0]              match_nxt;

`ifdef CLK_DIV_DETECT_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], tick_in};
  end
  assign tick_s = sync_q[1];
`else
  assign tick_s = tick_in;
`endif

  assign rise = tick_s & ~tick_q;

  // Exact-match decode: only 2**k with k in 0..DIV_MAX is a legal period.
  always_comb begin
    pow2  = 1'b0;
    dec_k = '0;
    for (int k = 0; k <= DIV_MAX; k++) begin
      if (cnt == (CNT_WIDTH'(1) << k)) begin
        pow2  = 1'b1;
        dec_k = CLK_DIV_SIZE'(k);
      end
    end
  end

  // A zero match count means no valid reference period yet.
  assign same      = (match_cnt != 4'd0) && (cnt == period_out);
  assign match_inc = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;
  assign match_nxt = same ? match_inc : 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      match_cnt  <= '0;
      tick_q     <= 1'b0;
      period_out <= '0;
      div_out    <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      tick_q <= tick_s;
      valid  <= 1'b0;
      if (!en) begin
        state     <= S_IDLE;
        cnt       <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
        err       <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_ARM;
          end
          default: begin
            if (rise) begin
              cnt     <= CNT_WIDTH'(1);
              timeout <= 1'b0;
              if (state == S_ARM) begin
                state     <= S_MEASURE;
                match_cnt <= '0;
              end else begin
                period_out <= cnt;
                valid      <= 1'b1;
                if (pow2) begin
                  div_out   <= dec_k;
                  err       <= 1'b0;
                  match_cnt <= match_nxt;
                  if (match_nxt >= 4'(LOCK_COUNT)) begin
                    state  <= S_LOCKED;
                    locked <= 1'b1;
                  end else begin
                    state  <= S_MEASURE;
                    locked <= 1'b0;
                  end
                end else begin
                  err       <= 1'b1;
                  match_cnt <= '0;
                  state     <= S_MEASURE;
                  locked    <= 1'b0;
                end
              end
            end else if (cnt == CNT_MAX) begin
              // Saturated with no rise: abandon the measurement and re-arm.
              timeout   <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              state     <= S_ARM;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_div_detector.sv
// Directed bench for clock_div_detector with default parameters (CNT_WIDTH=9, LOCK_COUNT=2).
module tb_clock_div_detector;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       tick_in;
  logic [8:0] period_out;
  logic [2:0] div_out;
  logic       valid;
  logic       locked;
  logic       err;
  logic       timeout;

  int pass_cnt;
  int total_cnt;

  clock_div_detector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tick_in    (tick_in),
    .period_out (period_out),
    .div_out    (div_out),
    .valid      (valid),
    .locked     (locked),
    .err        (err),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) cyc();
  endtask

  // One-cycle tick pulse; returns just after the edge that sees the rise.
  task automatic rise_edge();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    tick_in   = 1'b0;
    wait_n(3);
    chk("rst_period", 32'(period_out), 0);
    chk("rst_div", 32'(div_out), 0);
    chk("rst_flags", {28'd0, valid, locked, err, timeout}, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    cyc();

    // Period 8: first rise arms, second reports, third locks
    wait_n(2);
    rise_edge();
    chk("arm_rise_valid", 32'(valid), 0);
    wait_n(7);
    rise_edge();
    chk("p8_valid", 32'(valid), 1);
    chk("p8_period", 32'(period_out), 8);
    chk("p8_div", 32'(div_out), 3);
    chk("p8_unlocked", 32'(locked), 0);
    wait_n(7);
    rise_edge();
    chk("p8_locked", 32'(locked), 1);
    chk("p8_valid2", 32'(valid), 1);
    cyc();
    chk("valid_pulse_end", 32'(valid), 0);
    wait_n(2);

    // Switch to period 4 while locked
    rise_edge();
    chk("p4_period", 32'(period_out), 4);
    chk("p4_div", 32'(div_out), 2);
    chk("p4_unlock", 32'(locked), 0);
    wait_n(3);
    rise_edge();
    chk("p4_relock", 32'(locked), 1);

    // Period 6 is not a power of two
    wait_n(5);
    rise_edge();
    chk("p6_period", 32'(period_out), 6);
    chk("p6_err", 32'(err), 1);
    chk("p6_div_hold", 32'(div_out), 2);
    chk("p6_unlock", 32'(locked), 0);
    wait_n(5);
    rise_edge();
    chk("p6_still_unlocked", 32'(locked), 0);

    // Back to period 2
    wait_n(1);
    rise_edge();
    chk("p2_period", 32'(period_out), 2);
    chk("p2_err_clear", 32'(err), 0);
    chk("p2_div", 32'(div_out), 1);
    chk("p2_unlocked", 32'(locked), 0);
    wait_n(1);
    rise_edge();
    chk("p2_locked", 32'(locked), 1);

    // Hold tick low: counter saturates at 511
    wait_n(510);
    chk("pre_timeout", 32'(timeout), 0);
    chk("pre_timeout_locked", 32'(locked), 1);
    cyc();
    chk("timeout_set", 32'(timeout), 1);
    chk("timeout_unlock", 32'(locked), 0);
    wait_n(4);
    rise_edge();
    chk("timeout_clear", 32'(timeout), 0);
    chk("rearm_no_valid", 32'(valid), 0);
    wait_n(3);
    rise_edge();
    chk("resume_valid", 32'(valid), 1);
    chk("resume_period", 32'(period_out), 4);
    wait_n(3);
    rise_edge();
    chk("resume_locked", 32'(locked), 1);

    // Disable mid-period while locked
    wait_n(1);
    en = 1'b0;
    cyc();
    chk("dis_locked", 32'(locked), 0);
    chk("dis_valid", 32'(valid), 0);
    chk("dis_period_hold", 32'(period_out), 4);
    chk("dis_div_hold", 32'(div_out), 2);
    wait_n(3);
    en = 1'b1;
    cyc();
    wait_n(2);
    rise_edge();
    chk("reen_first_valid", 32'(valid), 0);
    chk("reen_first_period", 32'(period_out), 4);
    wait_n(7);
    rise_edge();
    chk("reen_second_valid", 32'(valid), 1);
    chk("reen_second_period", 32'(period_out), 8);
    chk("reen_second_div", 32'(div_out), 3);
    wait_n(7);
    rise_edge();
    chk("pre_arst_locked", 32'(locked), 1);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_period", 32'(period_out), 0);
    chk("arst_div", 32'(div_out), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_locked", 32'(locked), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
